// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator for the HDMI output path. Walks a horizontal and a
// vertical counter over the full raster and produces the per-channel inputs of
// three TMDS encoders:
//   - video data (vd_r/vd_g/vd_b) and the video-data-enable (vde)
//   - control data (cd_r/cd_g/cd_b), with {vsync, hsync} carried on cd_b
// During the active area one RGB pixel per clock is pulled from the upstream
// stream through a valid/ready handshake. The raster never stalls: a missing
// pixel is replaced by UNDERFLOW_COLOR and counted as an underflow.
//
// Ports
//   clk              pixel clock
//   rst              synchronous, active-high reset
//   pix_data[23:0]   upstream pixel {R, G, B}
//   pix_valid        pix_data valid
//   pix_ready        pixel accepted this cycle if pix_valid (combinational)
//   frame_start      pulse on the first active pixel slot of a frame (comb.)
//   vd_r/vd_g/vd_b   encoder video data (registered)
//   cd_r/cd_g/cd_b   encoder control data (registered)
//   vde              encoder video-data enable (registered)
//   underflow_frame  sticky per-frame underflow flag (registered)
//   underflow_count  saturating total underflow count (registered)
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33,
    parameter logic        HSYNC_POL       = 1'b0,
    parameter logic        VSYNC_POL       = 1'b0,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic [7:0]  vd_r,
    output logic [7:0]  vd_g,
    output logic [7:0]  vd_b,
    output logic [1:0]  cd_r,
    output logic [1:0]  cd_g,
    output logic [1:0]  cd_b,
    output logic        vde,
    output logic        underflow_frame,
    output logic [15:0] underflow_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // One extra bit so that region bounds equal to the total (zero back
    // porch) still fit and compare correctly.
    localparam int HXW     = HW + 1;
    localparam int VXW     = VW + 1;

    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [HXW-1:0] H_ACT_X   = HXW'(H_ACTIVE);
    localparam logic [HXW-1:0] H_SYNC_SX = HXW'(H_ACTIVE + H_FP);
    localparam logic [HXW-1:0] H_SYNC_EX = HXW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VXW-1:0] V_ACT_X   = VXW'(V_ACTIVE);
    localparam logic [VXW-1:0] V_SYNC_SX = VXW'(V_ACTIVE + V_FP);
    localparam logic [VXW-1:0] V_SYNC_EX = VXW'(V_ACTIVE + V_FP + V_SYNC);

    // Raster counters
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    // Registered encoder outputs and underflow accounting
    logic          vde_q, vde_d;
    logic [23:0]   vd_q, vd_d;
    logic [1:0]    cd_r_q, cd_r_d;
    logic [1:0]    cd_g_q, cd_g_d;
    logic [1:0]    cd_b_q, cd_b_d;
    logic          underflow_frame_q, underflow_frame_d;
    logic [15:0]   underflow_count_q, underflow_count_d;

    // Decoded raster state
    logic [HXW-1:0] h_ext;
    logic [VXW-1:0] v_ext;
    logic           active;
    logic           hsync_level;
    logic           vsync_level;
    logic           underflow_event;
    logic           at_origin;

    // Decode the current counter state into area, sync levels and handshake.
    always_comb begin
        h_ext           = {1'b0, h_q};
        v_ext           = {1'b0, v_q};
        active          = (h_ext < H_ACT_X) && (v_ext < V_ACT_X);
        at_origin       = (h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}});
        if ((h_ext >= H_SYNC_SX) && (h_ext < H_SYNC_EX)) begin
            hsync_level = HSYNC_POL;
        end else begin
            hsync_level = ~HSYNC_POL;
        end
        if ((v_ext >= V_SYNC_SX) && (v_ext < V_SYNC_EX)) begin
            vsync_level = VSYNC_POL;
        end else begin
            vsync_level = ~VSYNC_POL;
        end
        // While rst is high the counters sit at the origin; masking with rst
        // keeps the handshake quiet until the raster actually starts.
        pix_ready       = active && !rst;
        frame_start     = at_origin && !rst;
        underflow_event = active && !pix_valid;
    end

    // Next-state logic for the counters and the registered outputs.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = {HW{1'b0}};
            if (v_q == V_LAST) begin
                v_d = {VW{1'b0}};
            end else begin
                v_d = v_q + VW'(1);
            end
        end else begin
            h_d = h_q + HW'(1);
        end

        vde_d  = active;
        cd_r_d = 2'b00;
        cd_g_d = 2'b00;
        cd_b_d = {vsync_level, hsync_level};

        if (active && pix_valid) begin
            vd_d = pix_data;
        end else if (active) begin
            vd_d = UNDERFLOW_COLOR;
        end else begin
            vd_d = 24'h000000;
        end

        if (underflow_event && (underflow_count_q != 16'hFFFF)) begin
            underflow_count_d = underflow_count_q + 16'd1;
        end else begin
            underflow_count_d = underflow_count_q;
        end

        // A missing first pixel of a frame must still flag that frame, so
        // setting takes priority over the frame_start clear.
        if (underflow_event) begin
            underflow_frame_d = 1'b1;
        end else if (frame_start) begin
            underflow_frame_d = 1'b0;
        end else begin
            underflow_frame_d = underflow_frame_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q               <= {HW{1'b0}};
            v_q               <= {VW{1'b0}};
            vde_q             <= 1'b0;
            vd_q              <= 24'h000000;
            cd_r_q            <= 2'b00;
            cd_g_q            <= 2'b00;
            cd_b_q            <= {~VSYNC_POL, ~HSYNC_POL};
            underflow_frame_q <= 1'b0;
            underflow_count_q <= 16'h0000;
        end else begin
            h_q               <= h_d;
            v_q               <= v_d;
            vde_q             <= vde_d;
            vd_q              <= vd_d;
            cd_r_q            <= cd_r_d;
            cd_g_q            <= cd_g_d;
            cd_b_q            <= cd_b_d;
            underflow_frame_q <= underflow_frame_d;
            underflow_count_q <= underflow_count_d;
        end
    end

    assign vd_r            = vd_q[23:16];
    assign vd_g            = vd_q[15:8];
    assign vd_b            = vd_q[7:0];
    assign cd_r            = cd_r_q;
    assign cd_g            = cd_g_q;
    assign cd_b            = cd_b_q;
    assign vde             = vde_q;
    assign underflow_frame = underflow_frame_q;
    assign underflow_count = underflow_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Self-checking bench for video_timing_gen. A small raster (H 4/1/2/1,
// V 3/1/1/1, POL=0, UNDERFLOW_COLOR=FF00FF) is driven one cycle at a time;
// each driven cycle pushes the expected registered outputs into a queue which
// a separate monitor pops and compares one cycle later. A second instance
// with a mostly-active raster and no source runs in parallel to drive the
// underflow counter into saturation.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic [7:0]  vd_r, vd_g, vd_b;
    logic [1:0]  cd_r, cd_g, cd_b;
    logic        vde;
    logic        underflow_frame;
    logic [15:0] underflow_count;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut (
        .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .frame_start(frame_start),
        .vd_r(vd_r), .vd_g(vd_g), .vd_b(vd_b),
        .cd_r(cd_r), .cd_g(cd_g), .cd_b(cd_b), .vde(vde),
        .underflow_frame(underflow_frame), .underflow_count(underflow_count)
    );

    // Saturation instance: 128x128 raster, 125x125 active, source always empty
    logic        rst2;
    logic [23:0] pix_data2;
    logic        pix_valid2;
    logic        pix_ready2;
    logic        frame_start2;
    logic [7:0]  vd_r2, vd_g2, vd_b2;
    logic [1:0]  cd_r2, cd_g2, cd_b2;
    logic        vde2;
    logic        uf_frame2;
    logic [15:0] uf_cnt2;

    video_timing_gen #(
        .H_ACTIVE(125), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(125), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut_sat (
        .clk(clk), .rst(rst2), .pix_data(pix_data2), .pix_valid(pix_valid2),
        .pix_ready(pix_ready2), .frame_start(frame_start2),
        .vd_r(vd_r2), .vd_g(vd_g2), .vd_b(vd_b2),
        .cd_r(cd_r2), .cd_g(cd_g2), .cd_b(cd_b2), .vde(vde2),
        .underflow_frame(uf_frame2), .underflow_count(uf_cnt2)
    );

    typedef struct packed {
        logic        vde;
        logic [23:0] vd;
        logic [1:0]  cd_r;
        logic [1:0]  cd_g;
        logic [1:0]  cd_b;
        logic        uf_frame;
        logic [15:0] uf_cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          mh = 0;
    int          mv = 0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_frame = 1'b0;
    int          xfers = 0;
    logic        sat_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One raster cycle: drive inputs, check the handshake outputs, and queue
    // the registered outputs expected after the next clock edge.
    task automatic step(input logic r, input logic valid, input logic [23:0] data);
        exp_t e;
        logic act;
        logic fs;
        @(negedge clk);
        rst       = r;
        pix_valid = valid;
        pix_data  = data;
        #1;
        act = (mh < 4) && (mv < 3);
        fs  = (mh == 0) && (mv == 0);
        check("pix_ready", pix_ready, !r && act);
        check("frame_start", frame_start, !r && fs);
        e.cd_r = 2'b00;
        e.cd_g = 2'b00;
        if (r) begin
            e.vde = 1'b0;
            e.vd  = 24'h000000;
            e.cd_b = 2'b11;
            m_cnt = 16'd0;
            m_frame = 1'b0;
            mh = 0;
            mv = 0;
        end else begin
            if (act && valid) xfers++;
            if (act && !valid) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_frame = 1'b1;
            end else if (fs) begin
                m_frame = 1'b0;
            end
            e.vde = act;
            e.vd  = !act ? 24'h000000 : (valid ? data : 24'hFF00FF);
            // hsync low at h=5,6 on every line; vsync low for the whole of v=4
            e.cd_b = {(mv == 4) ? 1'b0 : 1'b1, (mh == 5 || mh == 6) ? 1'b0 : 1'b1};
            mh++;
            if (mh == 8) begin
                mh = 0;
                mv = (mv == 5) ? 0 : mv + 1;
            end
        end
        e.uf_cnt   = m_cnt;
        e.uf_frame = m_frame;
        sb_q.push_back(e);
    endtask

    // mode 0: source always valid; 1: slots 5 and 6 missing; 2: slot 0 missing.
    // Outside the active area pix_valid is held high with junk data.
    task automatic drive(input int mode, input int base, input int n);
        int   slot;
        logic valid;
        for (int i = 0; i < n; i++) begin
            if ((mh < 4) && (mv < 3)) begin
                slot  = mv * 4 + mh;
                valid = !((mode == 1) && (slot == 5 || slot == 6)) &&
                        !((mode == 2) && (slot == 0));
                step(1'b0, valid, 24'(base + slot));
            end else begin
                step(1'b0, 1'b1, 24'hABCDEF);
            end
        end
    endtask

    // Monitor: compare every registered output against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("vde", vde, e.vde);
            check("vd", {vd_r, vd_g, vd_b}, e.vd);
            check("cd_r", cd_r, e.cd_r);
            check("cd_g", cd_g, e.cd_g);
            check("cd_b", cd_b, e.cd_b);
            check("underflow_frame", underflow_frame, e.uf_frame);
            check("underflow_count", underflow_count, e.uf_cnt);
        end
    end

    // Main directed sequence.
    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 24'h000000;
        repeat (3) step(1'b1, 1'b0, 24'h000000);

        xfers = 0;
        drive(0, 0, 48);
        check("transfers_per_frame", xfers, 12);

        drive(1, 100, 48);
        @(posedge clk);
        #2;
        check("uf_count_after_drop", underflow_count, 16'd2);
        check("uf_frame_after_drop", underflow_frame, 1'b1);

        drive(0, 200, 48);
        drive(2, 300, 48);
        @(posedge clk);
        #2;
        check("uf_count_first_slot", underflow_count, 16'd3);
        check("uf_frame_first_slot", underflow_frame, 1'b1);

        // Run into the frame until h=2, v=1, then reset there.
        drive(0, 400, 10);
        step(1'b1, 1'b1, 24'h000000);
        step(1'b1, 1'b1, 24'h000000);
        @(posedge clk);
        #2;
        check("uf_count_after_reset", underflow_count, 16'd0);
        drive(0, 500, 48);

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);

        while (!sat_done) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Saturation: every active slot of dut_sat is an underflow (15625 per
    // 16384-cycle frame).
    initial begin
        rst2       = 1'b1;
        pix_valid2 = 1'b0;
        pix_data2  = 24'h123456;
        repeat (2) @(negedge clk);
        rst2 = 1'b0;
        repeat (16384) @(negedge clk);
        check("sat_one_frame_count", uf_cnt2, 16'd15625);
        check("sat_uf_frame", uf_frame2, 1'b1);
        // 68642 cycles -> 65534 underflows
        repeat (68642 - 16384) @(negedge clk);
        check("sat_below_max", uf_cnt2, 16'hFFFE);
        // 68648 cycles -> 65540 underflows
        repeat (6) @(negedge clk);
        check("sat_at_max", uf_cnt2, 16'hFFFF);
        repeat (200) @(negedge clk);
        check("sat_holds", uf_cnt2, 16'hFFFF);
        sat_done = 1'b1;
    end

endmodule
